// File: rtl/alu_mc_if.sv
// Operand/opcode request and result/flag response bundle for alu_mc.
// Handshakes: a transfer happens on a rising clk edge when valid and ready are both 1.
interface alu_mc_if #(
    parameter int BUS_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           opcode;
    logic [BUS_WIDTH-1:0] num_0;
    logic [BUS_WIDTH-1:0] num_1;
    logic                 out_valid;
    logic                 out_ready;
    logic [BUS_WIDTH-1:0] num_out;
    logic                 over_flag;
    logic                 zero_flag;
    logic                 greater_flag;
    logic                 equal_flag;

    // Requester side: drives operands and takes results.
    modport master (
        output in_valid, opcode, num_0, num_1, out_ready,
        input  in_ready, out_valid, num_out,
        input  over_flag, zero_flag, greater_flag, equal_flag
    );

    // ALU side.
    modport slave (
        input  in_valid, opcode, num_0, num_1, out_ready,
        output in_ready, out_valid, num_out,
        output over_flag, zero_flag, greater_flag, equal_flag
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative MUL and (optional) DIV.
// Define ALU_MC_DIV_EN to build the restoring divider; otherwise DIV behaves as NUL.
module alu_mc #(
    parameter int BUS_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_mc_if.slave      bus,
    output logic [1:0]   dbg_state
);
    localparam int W     = BUS_WIDTH;
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0] OP_DIV = 4'b0110;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]     a, b;
    logic             accept;
    logic             dec_mul, dec_div, dec_multi;

    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     acc_hi, acc_lo, b_reg;
    logic             div_sel;
    logic             eq_q, gt_q;

    logic [W-1:0]     sc_res;
    logic             sc_ovf;
    logic [W:0]       add_sum;
    logic [W-1:0]     shamt;
    logic [2*W-1:0]   shl_full, shr_full;

    logic [W:0]       mul_sum;
    logic [W-1:0]     mul_hi_nxt, mul_lo_nxt;
    logic [W-1:0]     div_hi_nxt, div_lo_nxt;
    logic [W-1:0]     it_hi_nxt, it_lo_nxt;

    assign a         = bus.num_0;
    assign b         = bus.num_1;
    assign accept    = bus.in_valid & bus.in_ready;
    assign dec_mul   = (bus.opcode == OP_MUL);
`ifdef ALU_MC_DIV_EN
    assign dec_div   = (bus.opcode == OP_DIV);
`else
    assign dec_div   = 1'b0;
`endif
    assign dec_multi = dec_mul | dec_div;

    // Handshake status comes straight from the state register.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign dbg_state     = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = dec_multi ? EXEC : DONE;
            EXEC: if (cnt == LAST) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle operations, evaluated on the live inputs at accept.
    always_comb begin
        sc_res   = '0;
        sc_ovf   = 1'b0;
        add_sum  = {1'b0, a} + {1'b0, b};
        shamt    = b % W'(W);
        shl_full = {{W{1'b0}}, a} << shamt;
        shr_full = {a, {W{1'b0}}} >> shamt;
        case (bus.opcode)
            OP_ADD: begin
                sc_res = add_sum[W-1:0];
                sc_ovf = add_sum[W];
            end
            OP_SUB: begin
                if (a < b) begin
                    sc_res = b - a;
                    sc_ovf = 1'b1;
                end else begin
                    sc_res = a - b;
                end
            end
            OP_XOR: sc_res = a ^ b;
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_SHL: begin
                sc_res = shl_full[W-1:0];
                sc_ovf = |shl_full[2*W-1:W];
            end
            OP_SHR: begin
                sc_res = shr_full[2*W-1:W];
                sc_ovf = |shr_full[W-1:0];
            end
            default: begin
                sc_res = '0;
                sc_ovf = 1'b0;
            end
        endcase
    end

    // Shift-add multiply step: {acc_hi, acc_lo} holds {partial, remaining multiplier}.
    always_comb begin
        mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_reg} : {(W+1){1'b0}});
        mul_hi_nxt = mul_sum[W:1];
        mul_lo_nxt = {mul_sum[0], acc_lo[W-1:1]};
    end

`ifdef ALU_MC_DIV_EN
    // Restoring divide step: acc_hi is the remainder, acc_lo shifts dividend out and quotient in.
    // A zero divisor always "fits", so the quotient naturally becomes all ones.
    logic [W:0]   div_shift;
    logic         div_ge;
    logic [W-1:0] div_diff;

    always_comb begin
        div_shift  = {acc_hi, acc_lo[W-1]};
        div_ge     = (div_shift >= {1'b0, b_reg});
        div_diff   = W'(div_shift - {1'b0, b_reg});
        div_hi_nxt = div_ge ? div_diff : div_shift[W-1:0];
        div_lo_nxt = {acc_lo[W-2:0], div_ge};
    end
`else
    assign div_hi_nxt = '0;
    assign div_lo_nxt = '0;
`endif

    assign it_hi_nxt = div_sel ? div_hi_nxt : mul_hi_nxt;
    assign it_lo_nxt = div_sel ? div_lo_nxt : mul_lo_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt              <= '0;
            acc_hi           <= '0;
            acc_lo           <= '0;
            b_reg            <= '0;
            div_sel          <= 1'b0;
            eq_q             <= 1'b0;
            gt_q             <= 1'b0;
            bus.num_out      <= '0;
            bus.over_flag    <= 1'b0;
            bus.zero_flag    <= 1'b1;
            bus.greater_flag <= 1'b0;
            bus.equal_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt  <= '0;
                        eq_q <= (a == b);
                        gt_q <= (a > b);
                        if (dec_multi) begin
                            acc_hi  <= '0;
                            acc_lo  <= a;
                            b_reg   <= b;
                            div_sel <= dec_div;
                        end else begin
                            bus.num_out      <= sc_res;
                            bus.over_flag    <= sc_ovf;
                            bus.zero_flag    <= (sc_res == '0);
                            bus.equal_flag   <= (a == b);
                            bus.greater_flag <= (a > b);
                        end
                    end
                end
                EXEC: begin
                    acc_hi <= it_hi_nxt;
                    acc_lo <= it_lo_nxt;
                    cnt    <= cnt + 1'b1;
                    // The last iteration's result is published on the same edge.
                    if (cnt == LAST) begin
                        cnt              <= '0;
                        bus.num_out      <= it_lo_nxt;
                        bus.over_flag    <= div_sel ? (b_reg == '0) : (|mul_hi_nxt);
                        bus.zero_flag    <= (it_lo_nxt == '0);
                        bus.equal_flag   <= eq_q;
                        bus.greater_flag <= gt_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at BUS_WIDTH=8; mirrors ALU_MC_DIV_EN for the DIV expectations.
module tb_alu_mc;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         total = 0;
    int         bad   = 0;

    alu_mc_if #(.BUS_WIDTH(8)) bus ();

    alu_mc #(.BUS_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] obs();
        return {bus.num_out, bus.over_flag, bus.zero_flag, bus.greater_flag, bus.equal_flag};
    endfunction

    // Called at #1 after a posedge with the ALU idle; returns at #1 after the
    // edge on which out_valid is seen (lat counts edges from accept, -1 on timeout).
    task automatic issue(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                         output int lat, output logic rdy_leak);
        lat      = -1;
        rdy_leak = 1'b0;
        bus.opcode   = op;
        bus.num_0    = x;
        bus.num_1    = y;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.opcode   = 4'($urandom_range(0, 15));
        bus.num_0    = 8'($urandom_range(0, 255));
        bus.num_1    = 8'($urandom_range(0, 255));
        for (int k = 1; k <= 40; k++) begin
            if (bus.out_valid) begin
                lat = k;
                break;
            end
            if (bus.in_ready) rdy_leak = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        total++;
        if (obs() !== 12'h004 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got=%h/%b/%b/%0d want=004/0/1/0", obs(), bus.out_valid, bus.in_ready, dbg_state);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (obs() !== 12'h004 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release got=%h/%b/%b want=004/0/1", obs(), bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_single();
        logic [3:0]  ops [15] = '{4'h1, 4'h2, 4'h2, 4'h3, 4'h4, 4'h8, 4'h0, 4'hF,
                                  4'h7, 4'h7, 4'h9, 4'h9, 4'h7, 4'h7, 4'hA};
        logic [7:0]  xs  [15] = '{8'd200, 8'd5, 8'd7, 8'hF0, 8'hF0, 8'hF0, 8'd12, 8'd9,
                                  8'h81, 8'h01, 8'h81, 8'h80, 8'h5A, 8'h80, 8'd3};
        logic [7:0]  ys  [15] = '{8'd100, 8'd9, 8'd7, 8'h3C, 8'h3C, 8'h3C, 8'd34, 8'd9,
                                  8'd1, 8'd9, 8'd1, 8'd7, 8'd8, 8'd3, 8'd2};
        // {num_out, over, zero, greater, equal}
        logic [11:0] exp [15] = '{{8'd44, 4'b1010}, {8'd4, 4'b1000}, {8'd0, 4'b0101},
                                  {8'hCC, 4'b0010}, {8'h30, 4'b0010}, {8'hFC, 4'b0010},
                                  {8'h00, 4'b0100}, {8'h00, 4'b0101}, {8'h02, 4'b1010},
                                  {8'h02, 4'b0000}, {8'h40, 4'b1010}, {8'h01, 4'b0010},
                                  {8'h5A, 4'b0010}, {8'h00, 4'b1110}, {8'h00, 4'b0110}};
        int   lat;
        logic leak;
        for (int i = 0; i < 15; i++) begin
            issue(ops[i], xs[i], ys[i], lat, leak);
            total++;
            if (lat !== 1) begin
                bad++;
                $display("FAIL single_lat[%0d] op=%h got=%0d want=1", i, ops[i], lat);
            end
            total++;
            if (obs() !== exp[i]) begin
                bad++;
                $display("FAIL single_res[%0d] op=%h got=%h want=%h", i, ops[i], obs(), exp[i]);
            end
            drain();
        end
    endtask

    task automatic test_mul();
        logic [7:0]  xs  [3] = '{8'd16, 8'd12, 8'd0};
        logic [7:0]  ys  [3] = '{8'd17, 8'd10, 8'd200};
        logic [11:0] exp [3] = '{{8'd16, 4'b1000}, {8'd120, 4'b0010}, {8'd0, 4'b0100}};
        int   lat;
        logic leak;
        for (int i = 0; i < 3; i++) begin
            issue(4'h5, xs[i], ys[i], lat, leak);
            total++;
            if (lat !== 9 || leak !== 1'b0 || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL mul_timing[%0d] lat=%0d leak=%b rdy=%b want lat=9 leak=0 rdy=0", i, lat, leak, bus.in_ready);
            end
            total++;
            if (obs() !== exp[i]) begin
                bad++;
                $display("FAIL mul_res[%0d] got=%h want=%h", i, obs(), exp[i]);
            end
            drain();
        end
    endtask

    task automatic test_div();
`ifdef ALU_MC_DIV_EN
        logic [7:0]  xs  [3] = '{8'd100, 8'd5, 8'd200};
        logic [7:0]  ys  [3] = '{8'd7, 8'd0, 8'd200};
        logic [11:0] exp [3] = '{{8'd14, 4'b0010}, {8'd255, 4'b1010}, {8'd1, 4'b0001}};
        int          want_lat = 9;
`else
        logic [7:0]  xs  [3] = '{8'd100, 8'd5, 8'd200};
        logic [7:0]  ys  [3] = '{8'd7, 8'd0, 8'd200};
        logic [11:0] exp [3] = '{{8'd0, 4'b0110}, {8'd0, 4'b0110}, {8'd0, 4'b0101}};
        int          want_lat = 1;
`endif
        int   lat;
        logic leak;
        for (int i = 0; i < 3; i++) begin
            issue(4'h6, xs[i], ys[i], lat, leak);
            total++;
            if (lat !== want_lat) begin
                bad++;
                $display("FAIL div_lat[%0d] got=%0d want=%0d", i, lat, want_lat);
            end
            total++;
            if (obs() !== exp[i]) begin
                bad++;
                $display("FAIL div_res[%0d] got=%h want=%h", i, obs(), exp[i]);
            end
            drain();
        end
    endtask

    task automatic test_back_to_back_pressure();
        int   lat;
        logic leak;
        bus.out_ready = 1'b0;
        issue(4'h1, 8'd3, 8'd4, lat, leak);
        total++;
        if (lat !== 1 || obs() !== {8'd7, 4'b0000}) begin
            bad++;
            $display("FAIL bp_first lat=%0d got=%h want lat=1 res=070", lat, obs());
        end
        bus.in_valid = 1'b1;
        bus.opcode   = 4'h1;
        bus.num_0    = 8'd50;
        bus.num_1    = 8'd60;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || obs() !== {8'd7, 4'b0000}) begin
                bad++;
                $display("FAIL bp_hold[%0d] ov=%b rdy=%b got=%h want ov=1 rdy=0 res=070", c, bus.out_valid, bus.in_ready, obs());
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL bp_release rdy=%b ov=%b st=%0d want rdy=1 ov=0 st=0", bus.in_ready, bus.out_valid, dbg_state);
        end
        bus.in_valid = 1'b0;
        // The held-off request is now accepted normally.
        issue(4'h1, 8'd50, 8'd60, lat, leak);
        total++;
        if (lat !== 1 || obs() !== {8'd110, 4'b0000}) begin
            bad++;
            $display("FAIL bp_next lat=%0d got=%h want lat=1 res=6e0", lat, obs());
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic leak;
        issue(4'h1, 8'd9, 8'd9, lat, leak);
        drain();
        bus.opcode   = 4'h5;
        bus.num_0    = 8'd16;
        bus.num_1    = 8'd17;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs() !== 12'h004 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL rst_mid got=%h/%b/%b/%0d want=004/0/1/0", obs(), bus.out_valid, bus.in_ready, dbg_state);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || obs() !== 12'h004) begin
            bad++;
            $display("FAIL rst_residue ov=%b got=%h want ov=0 res=004", bus.out_valid, obs());
        end
        issue(4'h1, 8'd1, 8'd1, lat, leak);
        total++;
        if (lat !== 1 || obs() !== {8'd2, 4'b0001}) begin
            bad++;
            $display("FAIL rst_after_add lat=%0d got=%h want lat=1 res=021", lat, obs());
        end
        drain();
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.opcode    = 4'h0;
        bus.num_0     = 8'd0;
        bus.num_1     = 8'd0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_mul();
        test_div();
        test_back_to_back_pressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
